// File: rtl/dac_spi_pkg.sv
// Shared widths, default DAC command bytes and the transaction state encoding
// for the dual-channel SPI DAC driver.
package dac_spi_pkg;

   localparam int FRAME_W = 24;
   localparam int DATA_W  = 16;
   localparam int CMD_W   = 8;

   localparam logic [CMD_W-1:0] CMD_A_DEFAULT = 8'h10;
   localparam logic [CMD_W-1:0] CMD_B_DEFAULT = 8'h11;

   typedef enum logic [2:0] {
      IDLE,
      SHIFT_A,
      GAP_A,
      SHIFT_B,
      GAP_B,
      LDAC
   } state_t;

endpackage

// File: rtl/dac_spi_driver_if.sv
// Sample-in / DAC-pins-out bundle between the sin/cos generator, the driver
// and the external DAC.
interface dac_spi_driver_if;

   logic                          i_enable;
   logic [dac_spi_pkg::DATA_W-1:0] i_cos;
   logic [dac_spi_pkg::DATA_W-1:0] i_sin;
   logic                          i_valid;
   logic                          o_sclk;
   logic                          o_mosi;
   logic                          o_cs_n;
   logic                          o_ldac_n;
   logic                          o_busy;
   logic                          o_done;
   logic                          o_overrun;

   modport slave (
      input  i_enable, i_cos, i_sin, i_valid,
      output o_sclk, o_mosi, o_cs_n, o_ldac_n, o_busy, o_done, o_overrun
   );

   modport master (
      output i_enable, i_cos, i_sin, i_valid,
      input  o_sclk, o_mosi, o_cs_n, o_ldac_n, o_busy, o_done, o_overrun
   );

endinterface

// File: rtl/spi_frame_tx.sv
// Single 24-bit SPI frame serialiser, CPOL=0, MSB first. o_done is high in the
// last cs-low cycle so the sequencer can move on without losing a cycle.
module spi_frame_tx
   import dac_spi_pkg::*;
#(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic               i_clk,
   input  logic               i_arst,
   input  logic               i_start,
   input  logic [FRAME_W-1:0] i_frame,
   output logic               o_sclk,
   output logic               o_mosi,
   output logic               o_cs_n,
   output logic               o_done
);

   localparam logic [7:0] HALF_LAST = 8'(CLK_DIV - 1);
   localparam logic [4:0] BIT_LAST  = 5'(FRAME_W - 1);

   logic               active;
   logic               sclk_q;
   logic [7:0]         half_cnt;
   logic [4:0]         bit_cnt;
   logic [FRAME_W-1:0] shreg;
   logic               half_end;

   assign half_end = (half_cnt == HALF_LAST);

   // NOTE: non-blocking assignments here so every flop samples pre-edge values.
   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
         active   <= 1'b0;
         sclk_q   <= 1'b0;
         half_cnt <= '0;
         bit_cnt  <= '0;
         shreg    <= '0;
      end else if (i_start) begin
         active   <= 1'b1;
         sclk_q   <= 1'b0;
         half_cnt <= '0;
         bit_cnt  <= '0;
         shreg    <= i_frame;
      end else if (active) begin
         if (half_end) begin
            half_cnt <= '0;
            if (!sclk_q) begin
               sclk_q <= 1'b1;
            end else begin
               sclk_q <= 1'b0;
               // The last bit is left in place so mosi holds through the gap.
               if (bit_cnt == BIT_LAST) begin
                  active <= 1'b0;
               end else begin
                  bit_cnt <= bit_cnt + 5'd1;
                  shreg   <= {shreg[FRAME_W-2:0], 1'b0};
               end
            end
         end else begin
            half_cnt <= half_cnt + 8'd1;
         end
      end
   end

   assign o_sclk = sclk_q;
   assign o_mosi = shreg[FRAME_W-1];
   assign o_cs_n = !active;
   assign o_done = active && sclk_q && half_end && (bit_cnt == BIT_LAST);

endmodule

// File: rtl/dac_spi_driver.sv
// Writes each cos/sin pair to a dual-channel SPI DAC (A=cos, B=sin) and then
// pulses LDAC; a one-deep newest-wins buffer keeps the generator from stalling.
module dac_spi_driver
   import dac_spi_pkg::*;
#(
   parameter int unsigned      CLK_DIV = 4,
   parameter int unsigned      CS_GAP  = 4,
   parameter logic [CMD_W-1:0] CMD_A   = CMD_A_DEFAULT,
   parameter logic [CMD_W-1:0] CMD_B   = CMD_B_DEFAULT
) (
   input logic             i_clk,
   input logic             i_arst,
   dac_spi_driver_if.slave bus
);

   if (CLK_DIV < 1 || CLK_DIV > 255 || CS_GAP < 1 || CS_GAP > 255) begin : g_param_check
      $error("dac_spi_driver: CLK_DIV and CS_GAP must be in 1..255");
   end

   localparam logic [7:0] GAP_LAST  = 8'(CS_GAP - 1);
   localparam logic [7:0] LDAC_LAST = 8'(CLK_DIV - 1);

   state_t              state, state_next;
   logic [7:0]          cnt, cnt_next;
   logic [DATA_W-1:0]   sin_q, pend_cos, pend_sin;
   logic                pend_valid;
   logic                busy_q, done_q, ldac_n_q, overrun_q;
   logic                take, idle_free, from_pend, start_txn, pend_wr;
   logic [DATA_W-1:0]   start_cos, start_sin;
   logic                tx_start, tx_done;
   logic [FRAME_W-1:0]  tx_frame;

   // The o_done cycle never starts a transaction, so a sample arriving then
   // is parked and launched one cycle later like any other pending pair.
   assign take      = bus.i_valid && bus.i_enable;
   assign idle_free = (state == IDLE) && !done_q;
   assign from_pend = idle_free && pend_valid;
   assign start_txn = idle_free && (pend_valid || take);
   assign start_cos = from_pend ? pend_cos : bus.i_cos;
   assign start_sin = from_pend ? pend_sin : bus.i_sin;
   assign pend_wr   = take && !(idle_free && !pend_valid);

   // NOTE: every output of this block gets a default first, so no latches.
   always_comb begin
      state_next = state;
      cnt_next   = '0;
      tx_start   = 1'b0;
      tx_frame   = {CMD_A, start_cos};
      case (state)
         IDLE: begin
            if (start_txn) begin
               tx_start   = 1'b1;
               state_next = SHIFT_A;
            end
         end
         SHIFT_A: if (tx_done) state_next = GAP_A;
         GAP_A: begin
            if (cnt == GAP_LAST) begin
               tx_start   = 1'b1;
               tx_frame   = {CMD_B, sin_q};
               state_next = SHIFT_B;
            end else begin
               cnt_next = cnt + 8'd1;
            end
         end
         SHIFT_B: if (tx_done) state_next = GAP_B;
         GAP_B: begin
            if (cnt == GAP_LAST) state_next = LDAC;
            else                 cnt_next   = cnt + 8'd1;
         end
         LDAC: begin
            if (cnt == LDAC_LAST) state_next = IDLE;
            else                  cnt_next   = cnt + 8'd1;
         end
         default: state_next = IDLE;
      endcase
   end

   // Status pins are registered from the next state so they line up with cs_n.
   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
         state    <= IDLE;
         cnt      <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         ldac_n_q <= 1'b1;
      end else begin
         state    <= state_next;
         cnt      <= cnt_next;
         busy_q   <= (state_next != IDLE);
         done_q   <= (state == LDAC) && (state_next == IDLE);
         ldac_n_q <= (state_next != LDAC);
      end
   end

   // NOTE: sample registers are reset as well, so a reset also discards the pending pair.
   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
         sin_q      <= '0;
         pend_cos   <= '0;
         pend_sin   <= '0;
         pend_valid <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         if (start_txn) sin_q <= start_sin;
         overrun_q <= pend_wr && pend_valid && !from_pend;
         if (pend_wr) begin
            pend_valid <= 1'b1;
            pend_cos   <= bus.i_cos;
            pend_sin   <= bus.i_sin;
         end else if (from_pend) begin
            pend_valid <= 1'b0;
         end
      end
   end

   spi_frame_tx #(
      .CLK_DIV (CLK_DIV)
   ) u_tx (
      .i_clk   (i_clk),
      .i_arst  (i_arst),
      .i_start (tx_start),
      .i_frame (tx_frame),
      .o_sclk  (bus.o_sclk),
      .o_mosi  (bus.o_mosi),
      .o_cs_n  (bus.o_cs_n),
      .o_done  (tx_done)
   );

   assign bus.o_busy    = busy_q;
   assign bus.o_done    = done_q;
   assign bus.o_ldac_n  = ldac_n_q;
   assign bus.o_overrun = overrun_q;

endmodule

// File: tb/tb_dac_spi_driver.sv
// Scoreboard bench: stimulus pushes hand-computed transactions, an SPI-side
// monitor rebuilds each transaction from the pins and compares at o_done.
module tb_dac_spi_driver;

   typedef struct {
      logic [23:0] fa;
      logic [23:0] fb;
      bit          ref_done;
      int          t_ref;
      int          lat;
      int          cs_low;
      int          gap;
      int          ldac_len;
      int          busy_len;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_err = 0;
   exp_t q0[$];
   exp_t q1[$];

   dac_spi_driver_if bus0 ();
   dac_spi_driver_if bus1 ();

   dac_spi_driver dut0 (
      .i_clk  (clk),
      .i_arst (rst),
      .bus    (bus0)
   );

   dac_spi_driver #(
      .CLK_DIV (1),
      .CS_GAP  (1)
   ) dut1 (
      .i_clk  (clk),
      .i_arst (rst),
      .bus    (bus1)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic sclk_w[2], mosi_w[2], cs_w[2], ldac_w[2], busy_w[2], done_w[2], ovr_w[2];
   assign sclk_w[0] = bus0.o_sclk;    assign sclk_w[1] = bus1.o_sclk;
   assign mosi_w[0] = bus0.o_mosi;    assign mosi_w[1] = bus1.o_mosi;
   assign cs_w[0]   = bus0.o_cs_n;    assign cs_w[1]   = bus1.o_cs_n;
   assign ldac_w[0] = bus0.o_ldac_n;  assign ldac_w[1] = bus1.o_ldac_n;
   assign busy_w[0] = bus0.o_busy;    assign busy_w[1] = bus1.o_busy;
   assign done_w[0] = bus0.o_done;    assign done_w[1] = bus1.o_done;
   assign ovr_w[0]  = bus0.o_overrun; assign ovr_w[1]  = bus1.o_overrun;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic exp_t mk_exp(input int g, input logic [15:0] c, input logic [15:0] s,
                                   input bit rd, input int t);
      exp_t e;
      e.fa       = {8'h10, c};
      e.fb       = {8'h11, s};
      e.ref_done = rd;
      e.t_ref    = t;
      e.lat      = rd ? 2 : 1;
      if (g == 0) begin
         e.cs_low = 192; e.gap = 4; e.ldac_len = 4; e.busy_len = 396;
      end else begin
         e.cs_low = 48;  e.gap = 1; e.ldac_len = 1; e.busy_len = 99;
      end
      return e;
   endfunction

   // Monitor state, one slot per DUT.
   logic        p_sclk[2], p_cs[2], p_ldac[2], p_busy[2];
   logic [23:0] sh[2];
   logic [23:0] fr[2][2];
   int          frlow[2][2], frbits[2][2];
   int          nbits[2], nfr[2], nldac[2], ldac_total[2];
   int          busy_rise[2], cs_fall[2], cs_rise[2], first_fall[2], gap_m[2];
   int          ldac_fall[2], ldac_len_m[2], last_done[2];
   int          cs_fall_cnt[2], ovr_cnt[2], ovr_cyc[2];

   always @(negedge clk) begin
      for (int g = 0; g < 2; g++) begin
         if (rst) begin
            nfr[g] = 0; nbits[g] = 0; nldac[g] = 0;
         end else begin
            if (busy_w[g] && !p_busy[g]) busy_rise[g] = cyc;
            if (!cs_w[g] && p_cs[g]) begin
               if (nfr[g] == 0) first_fall[g] = cyc;
               else             gap_m[g] = cyc - cs_rise[g];
               cs_fall[g] = cyc;
               nbits[g] = 0;
               cs_fall_cnt[g]++;
            end
            if (sclk_w[g] && !p_sclk[g] && !cs_w[g]) begin
               sh[g] = {sh[g][22:0], mosi_w[g]};
               nbits[g]++;
            end
            if (cs_w[g] && !p_cs[g]) begin
               cs_rise[g] = cyc;
               if (nfr[g] < 2) begin
                  fr[g][nfr[g]]     = sh[g];
                  frlow[g][nfr[g]]  = cyc - cs_fall[g];
                  frbits[g][nfr[g]] = nbits[g];
               end
               nfr[g]++;
            end
            if (!ldac_w[g] && p_ldac[g]) begin
               ldac_fall[g] = cyc; nldac[g]++; ldac_total[g]++;
            end
            if (ldac_w[g] && !p_ldac[g]) ldac_len_m[g] = cyc - ldac_fall[g];
            if (ovr_w[g]) begin
               ovr_cnt[g]++; ovr_cyc[g] = cyc;
            end
            if (done_w[g]) begin
               if ((g == 0 && q0.size() == 0) || (g == 1 && q1.size() == 0)) begin
                  check($sformatf("dut%0d unexpected_txn", g), 1, 0);
               end else begin
                  exp_t e;
                  int   rf;
                  e  = (g == 0) ? q0.pop_front() : q1.pop_front();
                  rf = e.ref_done ? last_done[g] : e.t_ref;
                  check($sformatf("dut%0d start_lat", g), first_fall[g] - rf, e.lat);
                  check($sformatf("dut%0d n_frames", g), nfr[g], 2);
                  check($sformatf("dut%0d frame_a", g), fr[g][0], e.fa);
                  check($sformatf("dut%0d frame_b", g), fr[g][1], e.fb);
                  check($sformatf("dut%0d bits_a", g), frbits[g][0], 24);
                  check($sformatf("dut%0d bits_b", g), frbits[g][1], 24);
                  check($sformatf("dut%0d cs_low_a", g), frlow[g][0], e.cs_low);
                  check($sformatf("dut%0d cs_low_b", g), frlow[g][1], e.cs_low);
                  check($sformatf("dut%0d gap", g), gap_m[g], e.gap);
                  check($sformatf("dut%0d ldac_pulses", g), nldac[g], 1);
                  check($sformatf("dut%0d ldac_len", g), ldac_len_m[g], e.ldac_len);
                  check($sformatf("dut%0d busy_len", g), cyc - busy_rise[g], e.busy_len);
                  check($sformatf("dut%0d busy_at_cs_fall", g), busy_rise[g], first_fall[g]);
                  check($sformatf("dut%0d busy_at_done", g), busy_w[g], 0);
               end
               last_done[g] = cyc;
               nfr[g] = 0;
               nldac[g] = 0;
            end
         end
         p_sclk[g] = rst ? 1'b0 : sclk_w[g];
         p_cs[g]   = rst ? 1'b1 : cs_w[g];
         p_ldac[g] = rst ? 1'b1 : ldac_w[g];
         p_busy[g] = rst ? 1'b0 : busy_w[g];
      end
   end

   // Caller is at a negedge; valid is held for exactly one clock cycle.
   task automatic send(input int g, input logic [15:0] c, input logic [15:0] s,
                       input bit push, input bit rd, output int t);
      t = cyc;
      if (push) begin
         if (g == 0) q0.push_back(mk_exp(g, c, s, rd, t));
         else        q1.push_back(mk_exp(g, c, s, rd, t));
      end
      if (g == 0) begin bus0.i_cos = c; bus0.i_sin = s; bus0.i_valid = 1'b1; end
      else        begin bus1.i_cos = c; bus1.i_sin = s; bus1.i_valid = 1'b1; end
      @(negedge clk);
      bus0.i_valid = 1'b0;
      bus1.i_valid = 1'b0;
   endtask

   task automatic wait_until(input int target);
      while (cyc < target) @(negedge clk);
   endtask

   task automatic wait_done(input int g, input int budget);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clk);
         seen = (g == 0) ? bus0.o_done : bus1.o_done;
      end
      if (!seen) check($sformatf("dut%0d done_timeout", g), 0, 1);
   endtask

   initial begin
      int t, t0, c0, o0, l0;
      for (int g = 0; g < 2; g++) begin
         ldac_total[g] = 0; cs_fall_cnt[g] = 0; ovr_cnt[g] = 0; ovr_cyc[g] = -1;
         last_done[g] = 0; nfr[g] = 0;
      end
      bus0.i_enable = 1'b1; bus0.i_valid = 1'b0; bus0.i_cos = '0; bus0.i_sin = '0;
      bus1.i_enable = 1'b1; bus1.i_valid = 1'b0; bus1.i_cos = '0; bus1.i_sin = '0;
      repeat (3) @(negedge clk);
      check("rst sclk", bus0.o_sclk, 0);
      check("rst mosi", bus0.o_mosi, 0);
      check("rst cs_n", bus0.o_cs_n, 1);
      check("rst ldac_n", bus0.o_ldac_n, 1);
      check("rst busy", bus0.o_busy, 0);
      check("rst done", bus0.o_done, 0);
      check("rst overrun", bus0.o_overrun, 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Basic transaction at default timing.
      send(0, 16'hA5C3, 16'h1234, 1, 0, t);
      wait_done(0, 600);
      check("basic done_latency", cyc - t, 397);

      // Fast timing instance.
      repeat (3) @(negedge clk);
      send(1, 16'hBEEF, 16'h0F0F, 1, 0, t);
      wait_done(1, 300);
      check("fast done_latency", cyc - t, 100);

      // Pending buffer and overrun.
      repeat (3) @(negedge clk);
      o0 = ovr_cnt[0];
      send(0, 16'h0001, 16'h0002, 1, 0, t0);
      wait_until(t0 + 10);
      send(0, 16'h0003, 16'h0004, 0, 0, t);
      wait_until(t0 + 20);
      send(0, 16'h0005, 16'h0006, 1, 1, t);
      wait_done(0, 600);
      check("overrun count", ovr_cnt[0] - o0, 1);
      check("overrun cycle", ovr_cyc[0] - t0, 21);
      wait_done(0, 600);
      check("overrun count after", ovr_cnt[0] - o0, 1);

      // Back-to-back: new sample on the o_done cycle.
      repeat (3) @(negedge clk);
      send(0, 16'h7FFF, 16'h8000, 1, 0, t);
      wait_done(0, 600);
      send(0, 16'h0000, 16'hFFFF, 1, 1, t);
      wait_done(0, 600);
      check("b2b overrun", ovr_cnt[0] - o0, 1);

      // Enable gating.
      repeat (3) @(negedge clk);
      bus0.i_enable = 1'b0;
      c0 = cs_fall_cnt[0];
      send(0, 16'h1111, 16'h2222, 0, 0, t);
      repeat (1000) @(negedge clk);
      check("disabled cs_activity", cs_fall_cnt[0] - c0, 0);
      check("disabled overrun", ovr_cnt[0] - o0, 1);
      bus0.i_enable = 1'b1;
      send(0, 16'hCAFE, 16'hF00D, 1, 0, t);
      repeat (50) @(negedge clk);
      bus0.i_enable = 1'b0;
      repeat (50) @(negedge clk);
      send(0, 16'h3333, 16'h4444, 0, 0, t);
      wait_done(0, 600);
      c0 = cs_fall_cnt[0];
      repeat (20) @(negedge clk);
      check("disabled no_followup", cs_fall_cnt[0] - c0, 0);
      bus0.i_enable = 1'b1;

      // Reset during frame B, bit 10, with a sample pending.
      repeat (3) @(negedge clk);
      send(0, 16'h5555, 16'hAAAA, 0, 0, t0);
      wait_until(t0 + 20);
      send(0, 16'h6666, 16'h7777, 0, 0, t);
      wait_until(t0 + 280);
      check("pre_rst cs_n", bus0.o_cs_n, 0);
      check("pre_rst frames_done", nfr[0], 1);
      l0 = ldac_total[0];
      #2 rst = 1'b1;
      #1;
      check("mid_rst cs_n", bus0.o_cs_n, 1);
      check("mid_rst sclk", bus0.o_sclk, 0);
      check("mid_rst busy", bus0.o_busy, 0);
      check("mid_rst ldac_n", bus0.o_ldac_n, 1);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      c0 = cs_fall_cnt[0];
      repeat (600) @(negedge clk);
      check("post_rst cs_activity", cs_fall_cnt[0] - c0, 0);
      check("post_rst ldac", ldac_total[0] - l0, 0);

      // Recovery after reset.
      send(0, 16'h0F0F, 16'hF0F0, 1, 0, t);
      wait_done(0, 600);

      repeat (5) @(negedge clk);
      check("q0 drained", q0.size(), 0);
      check("q1 drained", q1.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
